// File: rtl/stream_merge2_pkg.sv
// Shared definitions for the two-input round-robin stream merger:
// select/source encoding and the default message type.
package stream_merge2_pkg;

  localparam int P_NBITS_DEFAULT = 4;

  // The same encoding drives the mux select and is reported on out_src.
  localparam logic SEL_IN0 = 1'b0;
  localparam logic SEL_IN1 = 1'b1;

  typedef logic [P_NBITS_DEFAULT-1:0] msg_t;

  // Winner for a two-bit request vector. On a tie, or when nobody requests,
  // the priority pointer decides.
  function automatic logic rr_pick(input logic [1:0] req, input logic prio);
    logic pick;
    case (req)
      2'b01:   pick = SEL_IN0;
      2'b10:   pick = SEL_IN1;
      default: pick = prio;
    endcase
    return pick;
  endfunction

endpackage

// File: rtl/stream_merge2_arb.sv
// Two-requester round-robin arbiter. The priority pointer flips to the
// side that did not win whenever a grant is actually used (en).
module rr_arb2
  import stream_merge2_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic       grant,
  output logic       any_req
);

  logic prio;

  assign grant   = rr_pick(req, prio);
  assign any_req = |req;

  // NOTE: state flops use non-blocking assignments so every flop samples
  // values from before the clock edge, regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio <= SEL_IN0;
    end else if (en) begin
      prio <= ~grant;
    end
  end

endmodule

// File: rtl/stream_merge2_mux.sv
// Generic two-input multiplexor used for data steering.
module mux2 #(
  parameter int p_nbits = 4
) (
  input  logic [p_nbits-1:0] in0,
  input  logic [p_nbits-1:0] in1,
  input  logic               sel,
  output logic [p_nbits-1:0] out
);

  // NOTE: every output of a combinational block is assigned on every path
  // (default first), otherwise synthesis infers a latch.
  always_comb begin
    out = in0;
    if (sel) out = in1;
  end

endmodule

// File: rtl/stream_merge2.sv
// Round-robin merge of two val/rdy streams into a single one-entry output
// register. out_rdy is bypassed combinationally into the input readies.
module stream_merge2
  import stream_merge2_pkg::*;
#(
  parameter int p_nbits = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in0_val,
  output logic               in0_rdy,
  input  logic [p_nbits-1:0] in0_msg,
  input  logic               in1_val,
  output logic               in1_rdy,
  input  logic [p_nbits-1:0] in1_msg,
  output logic               out_val,
  input  logic               out_rdy,
  output logic [p_nbits-1:0] out_msg,
  output logic               out_src
);

  logic               space;
  logic               go;
  logic               grant;
  logic               any_req;
  logic [p_nbits-1:0] mux_out;

  // The register can accept when it is empty or being drained this cycle.
  assign space = !out_val || out_rdy;
  assign go    = space && any_req;

  assign in0_rdy = space && (grant == SEL_IN0) && in0_val;
  assign in1_rdy = space && (grant == SEL_IN1) && in1_val;

  rr_arb2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     ({in1_val, in0_val}),
    .en      (go),
    .grant   (grant),
    .any_req (any_req)
  );

  mux2 #(.p_nbits(p_nbits)) u_mux (
    .in0 (in0_msg),
    .in1 (in1_msg),
    .sel (grant),
    .out (mux_out)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_val <= 1'b0;
      out_msg <= '0;
      out_src <= SEL_IN0;
    end else begin
      out_val <= go || (out_val && !out_rdy);
      if (go) begin
        out_msg <= mux_out;
        out_src <= grant;
      end
    end
  end

endmodule

// File: tb/tb_stream_merge2.sv
// Directed self-checking bench for stream_merge2: reset, single stream,
// contention, backpressure and priority persistence.
module tb_stream_merge2;
  import stream_merge2_pkg::*;

  logic       clk;
  logic       reset_n;
  logic       in0_val, in0_rdy;
  msg_t       in0_msg;
  logic       in1_val, in1_rdy;
  msg_t       in1_msg;
  logic       out_val, out_rdy, out_src;
  msg_t       out_msg;

  int tests_run;
  int tests_failed;

  stream_merge2 #(.p_nbits(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .in0_val (in0_val),
    .in0_rdy (in0_rdy),
    .in0_msg (in0_msg),
    .in1_val (in1_val),
    .in1_rdy (in1_rdy),
    .in1_msg (in1_msg),
    .out_val (out_val),
    .out_rdy (out_rdy),
    .out_msg (out_msg),
    .out_src (out_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge and let outputs settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input msg_t m0, input logic v1,
                       input msg_t m1, input logic ordy);
    in0_val = v0; in0_msg = m0;
    in1_val = v1; in1_msg = m1;
    out_rdy = ordy;
    #1;
  endtask

  task automatic test_reset();
    // Fill the register with 4'hB under backpressure (prio moves to 1).
    drive(1'b1, 4'hB, 1'b0, 4'h0, 1'b0);
    tick();
    tests_run++;
    if (out_val !== 1'b1 || out_msg !== 4'hB) begin
      $display("FAIL reset_preload: val=%b msg=%h want val=1 msg=b", out_val, out_msg);
      tests_failed++;
    end
    drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
    #1 reset_n = 1'b0;
    #1;
    tests_run++;
    if (out_val !== 1'b0 || out_msg !== 4'h0 || out_src !== 1'b0) begin
      $display("FAIL reset_async: val=%b msg=%h src=%b want 0 0 0", out_val, out_msg, out_src);
      tests_failed++;
    end
    @(negedge clk);
    reset_n = 1'b1;
    drive(1'b1, 4'h2, 1'b1, 4'hD, 1'b1);
    tests_run++;
    if (in0_rdy !== 1'b1 || in1_rdy !== 1'b0) begin
      $display("FAIL reset_first_grant_rdy: rdy0=%b rdy1=%b want 1 0", in0_rdy, in1_rdy);
      tests_failed++;
    end
    tick();
    tests_run++;
    if (out_val !== 1'b1 || out_msg !== 4'h2 || out_src !== 1'b0) begin
      $display("FAIL reset_first_grant_out: val=%b msg=%h src=%b want 1 2 0", out_val, out_msg, out_src);
      tests_failed++;
    end
    drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
    tick();
  endtask

  task automatic test_single();
    msg_t vec [3];
    vec[0] = 4'h3; vec[1] = 4'h5; vec[2] = 4'hA;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, vec[i], 1'b0, 4'h0, 1'b1);
      tests_run++;
      if (in0_rdy !== 1'b1 || in1_rdy !== 1'b0) begin
        $display("FAIL single_rdy%0d: rdy0=%b rdy1=%b want 1 0", i, in0_rdy, in1_rdy);
        tests_failed++;
      end
      tick();
      tests_run++;
      if (out_val !== 1'b1 || out_msg !== vec[i] || out_src !== 1'b0) begin
        $display("FAIL single_out%0d: val=%b msg=%h src=%b want 1 %h 0", i, out_val, out_msg, out_src, vec[i]);
        tests_failed++;
      end
    end
    drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
    tick();
    tests_run++;
    if (out_val !== 1'b0) begin
      $display("FAIL single_drain: val=%b want 0", out_val);
      tests_failed++;
    end
  endtask

  task automatic test_contention();
    msg_t exp_msg;
    logic exp_src;
    // Reset first so the alternation starts from prio = 0.
    drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'h1, 1'b1, 4'hE, 1'b1);
      exp_src = (i % 2 == 1);
      exp_msg = exp_src ? 4'hE : 4'h1;
      tests_run++;
      if (in0_rdy !== !exp_src || in1_rdy !== exp_src || (in0_rdy && in1_rdy)) begin
        $display("FAIL contention_rdy%0d: rdy0=%b rdy1=%b want %b %b", i, in0_rdy, in1_rdy, !exp_src, exp_src);
        tests_failed++;
      end
      tick();
      tests_run++;
      if (out_val !== 1'b1 || out_msg !== exp_msg || out_src !== exp_src) begin
        $display("FAIL contention_out%0d: val=%b msg=%h src=%b want 1 %h %b", i, out_val, out_msg, out_src, exp_msg, exp_src);
        tests_failed++;
      end
    end
    drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
    tick();
  endtask

  task automatic test_backpressure();
    // prio is 0 here; in0 alone loads 7, which moves prio to 1.
    drive(1'b1, 4'h7, 1'b0, 4'h0, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'h4, 1'b1, 4'hC, 1'b0);
      tests_run++;
      if (in0_rdy !== 1'b0 || in1_rdy !== 1'b0) begin
        $display("FAIL bp_rdy%0d: rdy0=%b rdy1=%b want 0 0", i, in0_rdy, in1_rdy);
        tests_failed++;
      end
      tick();
      tests_run++;
      if (out_val !== 1'b1 || out_msg !== 4'h7 || out_src !== 1'b0) begin
        $display("FAIL bp_hold%0d: val=%b msg=%h src=%b want 1 7 0", i, out_val, out_msg, out_src);
        tests_failed++;
      end
    end
    drive(1'b1, 4'h4, 1'b1, 4'hC, 1'b1);
    tests_run++;
    if (in0_rdy !== 1'b0 || in1_rdy !== 1'b1) begin
      $display("FAIL bp_release_rdy: rdy0=%b rdy1=%b want 0 1", in0_rdy, in1_rdy);
      tests_failed++;
    end
    tick();
    tests_run++;
    if (out_val !== 1'b1 || out_msg !== 4'hC || out_src !== 1'b1) begin
      $display("FAIL bp_release_out: val=%b msg=%h src=%b want 1 c 1", out_val, out_msg, out_src);
      tests_failed++;
    end
    drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
    tick();
  endtask

  task automatic test_prio_persist();
    // in0 alone moves prio to 1, then in1 alone moves it back to 0.
    drive(1'b1, 4'h6, 1'b0, 4'h0, 1'b1);
    tick();
    drive(1'b0, 4'h0, 1'b1, 4'h9, 1'b1);
    tick();
    tests_run++;
    if (out_val !== 1'b1 || out_msg !== 4'h9 || out_src !== 1'b1) begin
      $display("FAIL prio_in1_out: val=%b msg=%h src=%b want 1 9 1", out_val, out_msg, out_src);
      tests_failed++;
    end
    drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
    tick();
    tests_run++;
    if (out_val !== 1'b0 || out_msg !== 4'h9) begin
      $display("FAIL prio_idle: val=%b msg=%h want 0 9", out_val, out_msg);
      tests_failed++;
    end
    tick();
    drive(1'b1, 4'h5, 1'b1, 4'hA, 1'b1);
    tests_run++;
    if (in0_rdy !== 1'b1 || in1_rdy !== 1'b0) begin
      $display("FAIL prio_next_rdy: rdy0=%b rdy1=%b want 1 0", in0_rdy, in1_rdy);
      tests_failed++;
    end
    tick();
    tests_run++;
    if (out_val !== 1'b1 || out_msg !== 4'h5 || out_src !== 1'b0) begin
      $display("FAIL prio_next_out: val=%b msg=%h src=%b want 1 5 0", out_val, out_msg, out_src);
      tests_failed++;
    end
    drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
    tick();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset_n = 1'b0;
    in0_val = 1'b0; in0_msg = '0;
    in1_val = 1'b0; in1_msg = '0;
    out_rdy = 1'b0;
    #1;
    tests_run++;
    if (out_val !== 1'b0 || out_msg !== 4'h0 || out_src !== 1'b0) begin
      $display("FAIL reset_initial: val=%b msg=%h src=%b want 0 0 0", out_val, out_msg, out_src);
      tests_failed++;
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    tick();
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_prio_persist();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
